// File: rtl/deserializer_pkg.sv
// -----------------------------------------------------------------------------
// deserializer_pkg
// Shared types and defaults for the serial-to-parallel receiver.
//   BYTE_W           : width of a received byte
//   DEF_SYNC_WORD    : default framing byte (received LSB first)
//   DEF_FRAME_BYTES  : default payload bytes between consecutive sync bytes
//   state_t          : receiver FSM states (HUNT, PAYLOAD, CHECK)
// -----------------------------------------------------------------------------
package deserializer_pkg;

  localparam int                BYTE_W          = 8;
  localparam logic [BYTE_W-1:0] DEF_SYNC_WORD   = 8'hA5;
  localparam int                DEF_FRAME_BYTES = 4;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

endpackage

// File: rtl/deser_out_reg.sv
// -----------------------------------------------------------------------------
// deser_out_reg
// One-entry valid/ready holding register for received payload bytes, with
// sticky overflow detection.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : a payload byte has completed this cycle
//   load_data  : the completed byte
//   ready      : consumer accepts the held byte when valid=1
//   data       : held byte (keeps its last value after being consumed)
//   valid      : data holds an unconsumed byte
//   overflow   : sticky; a byte was dropped because the register was full
// -----------------------------------------------------------------------------
module deser_out_reg
  import deserializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              ready,
  output logic [BYTE_W-1:0] data,
  output logic              valid,
  output logic              overflow
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      // A byte accepted on this same edge frees the slot for the new one.
      if (!valid || ready) begin
        data  <= load_data;
        valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
// Recovers bytes from an LSB-first serial stream, locks to SYNC_WORD, strips
// it, and presents FRAME_BYTES payload bytes per frame on a valid/ready port.
//   clk, rst        : clock, asynchronous active-high reset
//   data_in         : serial bit, used only when data_in_valid=1
//   data_in_valid   : bit qualifier; 0 freezes all receive state
//   data_out        : payload byte, bit 0 = first bit received
//   data_out_valid  : data_out holds an unconsumed byte
//   data_out_ready  : consumer accepts data_out
//   locked          : frame alignment acquired
//   sync_err        : one-cycle pulse when a sync slot holds the wrong byte
//   overflow        : sticky; a payload byte was dropped
// -----------------------------------------------------------------------------
module deserializer
  import deserializer_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_WORD   = DEF_SYNC_WORD,
  parameter int                FRAME_BYTES = DEF_FRAME_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  input  logic              data_in_valid,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic              locked,
  output logic              sync_err,
  output logic              overflow
);

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

  state_t            state, state_next;
  logic [BYTE_W-1:0] sr;
  logic [BYTE_W-1:0] sr_next;
  logic [2:0]        bit_cnt;
  logic [7:0]        byte_cnt;
  logic [2:0]        fill_cnt;   // saturates at 7: seven bits held, the current one makes eight
  logic              byte_end;
  logic              out_load;
  logic              sync_bad;

  // The byte as it stands once the current bit is shifted in; used for both
  // the sliding sync compare and byte completion on the same edge.
  assign sr_next  = {data_in, sr[BYTE_W-1:1]};
  assign byte_end = data_in_valid && (bit_cnt == 3'd7);
  assign locked   = (state != HUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    out_load   = 1'b0;
    sync_bad   = 1'b0;
    case (state)
      HUNT: begin
        if (data_in_valid && fill_cnt == 3'd7 && sr_next == SYNC_WORD)
          state_next = PAYLOAD;
      end
      PAYLOAD: begin
        if (byte_end) begin
          out_load = 1'b1;
          if (byte_cnt == LAST_BYTE) state_next = CHECK;
        end
      end
      CHECK: begin
        if (byte_end) begin
          if (sr_next == SYNC_WORD) begin
            state_next = PAYLOAD;
          end else begin
            state_next = HUNT;
            sync_bad   = 1'b1;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      fill_cnt <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= sync_bad;
      if (data_in_valid) begin
        sr <= sr_next;
        case (state)
          HUNT: begin
            // Counters sit at zero so the first payload bit starts a clean byte.
            bit_cnt  <= '0;
            byte_cnt <= '0;
            if (fill_cnt != 3'd7) fill_cnt <= fill_cnt + 3'd1;
          end
          PAYLOAD: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_end)
              byte_cnt <= (byte_cnt == LAST_BYTE) ? 8'd0 : byte_cnt + 8'd1;
          end
          CHECK: begin
            bit_cnt <= bit_cnt + 3'd1;
            // Back to HUNT: demand eight fresh bits before the next lock.
            if (sync_bad) fill_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  deser_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (out_load),
    .load_data (sr_next),
    .ready     (data_out_ready),
    .data      (data_out),
    .valid     (data_out_valid),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_deserializer.sv
// -----------------------------------------------------------------------------
// tb_deserializer
// Self-checking bench: a bit-stream level model (sliding window, frame position
// in bits, one-slot holding buffer) predicts every output each cycle; directed
// sequences pin the model with hand-computed values; a randomized phase with
// gaps, random ready and occasional bad sync bytes exercises the rest.
// -----------------------------------------------------------------------------
module tb_deserializer;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         FB   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_in = 1'b0;
  logic       data_in_valid = 1'b0;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready = 1'b0;
  logic       locked;
  logic       sync_err;
  logic       overflow;

  deserializer #(.SYNC_WORD(SYNC), .FRAME_BYTES(FB)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .locked         (locked),
    .sync_err       (sync_err),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_win;          // last eight bits seen, newest at bit 7
  int         m_hunt_bits;    // bits seen since (re)entering hunt
  bit         m_locked;
  int         m_pos;          // bits since the end of the last sync byte
  bit         m_sync_err;
  logic [7:0] m_data;
  bit         m_valid;
  bit         m_ovf;
  int         bit_idx;
  int         lock_bit_idx;
  int         sync_err_cnt;
  logic [7:0] emitted[$];
  bit         model_on = 1'b0;

  task automatic model_reset();
    m_win = '0; m_hunt_bits = 0; m_locked = 0; m_pos = 0; m_sync_err = 0;
    m_data = '0; m_valid = 0; m_ovf = 0;
    bit_idx = 0; lock_bit_idx = -1; sync_err_cnt = 0;
    emitted.delete();
  endtask

  task automatic model_step(input logic din, input logic dv, input logic rdy);
    bit         have_byte = 0;
    logic [7:0] nb = '0;
    m_sync_err = 0;
    if (dv) begin
      m_win = {din, m_win[7:1]};
      bit_idx++;
      if (!m_locked) begin
        m_hunt_bits++;
        if (m_hunt_bits >= 8 && m_win == SYNC) begin
          m_locked = 1; m_pos = 0; lock_bit_idx = bit_idx;
        end
      end else begin
        m_pos++;
        if (m_pos % 8 == 0) begin
          if (m_pos / 8 <= FB) begin
            have_byte = 1; nb = m_win;
          end else if (m_win == SYNC) begin
            m_pos = 0;
          end else begin
            m_locked = 0; m_hunt_bits = 0; m_sync_err = 1; sync_err_cnt++;
          end
        end
      end
    end
    if (have_byte) begin
      emitted.push_back(nb);
      if (!m_valid || rdy) begin
        m_data = nb; m_valid = 1;
      end else begin
        m_ovf = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  // Single compare process: advance the model on each edge, check #1 later.
  always @(posedge clk) begin
    if (model_on && !rst) begin
      model_step(data_in, data_in_valid, data_out_ready);
      #1;
      check("data_out",       data_out,       m_data);
      check("data_out_valid", data_out_valid, m_valid);
      check("locked",         locked,         m_locked);
      check("sync_err",       sync_err,       m_sync_err);
      check("overflow",       overflow,       m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  bit rdy_rand = 1'b0;
  bit rdy_val  = 1'b1;

  task automatic drive(input logic v, input logic d);
    @(negedge clk);
    data_in        = d;
    data_in_valid  = v;
    data_out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  endtask

  task automatic send_bit(input logic b);
    drive(1'b1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) drive(1'b0, 1'($urandom_range(0, 1)));
      send_bit(b[i]);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    data_in_valid = 1'b0;
    model_reset();
    #1;
    check("rst data_out",       data_out,       8'h00);
    check("rst data_out_valid", data_out_valid, 1'b0);
    check("rst locked",         locked,         1'b0);
    check("rst sync_err",       sync_err,       1'b0);
    check("rst overflow",       overflow,       1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    model_on = 1'b1;

    // Lock and receive
    rdy_rand = 0; rdy_val = 1;
    send_byte(8'hA5, 0); send_byte(8'h3C, 0); send_byte(8'hC3, 0); send_byte(8'hA5, 0);
    idle(2);
    check("lock bit index",  lock_bit_idx,   8);
    check("t1 byte count",   emitted.size(), 2);
    if (emitted.size() == 2) begin
      check("t1 byte0", emitted[0], 8'h3C);
      check("t1 byte1", emitted[1], 8'hC3);
    end
    check("t1 locked", locked, 1'b1);

    // Bad sync, then relock
    emitted.delete();
    send_byte(8'h77, 0); send_byte(8'h88, 0); send_byte(8'h5A, 0);
    idle(2);
    check("bad sync err count", sync_err_cnt,   1);
    check("bad sync locked",    locked,         1'b0);
    check("bad sync bytes",     emitted.size(), 2);
    send_byte(8'hA5, 0); send_byte(8'h99, 0);
    idle(1);
    check("relock", locked, 1'b1);

    // Misaligned hunt
    do_reset();
    send_bit(1); send_bit(0); send_bit(1);
    send_byte(8'hA5, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    idle(2);
    check("misaligned lock index", lock_bit_idx,   11);
    check("misaligned count",      emitted.size(), 2);
    if (emitted.size() == 2) begin
      check("misaligned byte0", emitted[0], 8'h11);
      check("misaligned byte1", emitted[1], 8'h22);
    end

    // Backpressure
    do_reset();
    rdy_val = 0;
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    idle(2);
    check("bp data",     data_out,       8'h01);
    check("bp valid",    data_out_valid, 1'b1);
    check("bp overflow", overflow,       1'b1);
    rdy_val = 1; idle(1); rdy_val = 0; idle(1);
    check("bp drained valid", data_out_valid, 1'b0);
    check("bp sticky ovf",    overflow,       1'b1);
    check("bp data held",     data_out,       8'h01);

    // Simultaneous accept and load
    do_reset();
    rdy_val = 0;
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    b = 8'h02;
    for (int i = 0; i < 7; i++) send_bit(b[i]);
    rdy_val = 1; send_bit(b[7]); rdy_val = 0;
    idle(2);
    check("simul data",     data_out,       8'h02);
    check("simul valid",    data_out_valid, 1'b1);
    check("simul overflow", overflow,       1'b0);

    // Randomized frames with gaps, random ready, occasional bad sync / junk
    do_reset();
    rdy_rand = 1;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h00;
        send_byte(b, 1);
      end else begin
        send_byte(SYNC, 1);
      end
      if ($urandom_range(0, 15) == 0) repeat ($urandom_range(1, 7)) send_bit(1'($urandom_range(0, 1)));
      for (int k = 0; k < FB; k++) send_byte(8'($urandom_range(0, 255)), 1);
    end
    idle(4);

    // Mid-byte reset with outputs set, then gapped reception after it
    rdy_rand = 0; rdy_val = 0;
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    send_bit(1); send_bit(1); send_bit(0);
    check("pre-rst locked",   locked,   1'b1);
    check("pre-rst overflow", overflow, 1'b1);
    do_reset();
    rdy_rand = 1;
    send_byte(8'hA5, 1); send_byte(8'h5E, 1); send_byte(8'hE7, 1);
    idle(2);
    check("gap count", emitted.size(), 2);
    if (emitted.size() == 2) begin
      check("gap byte0", emitted[0], 8'h5E);
      check("gap byte1", emitted[1], 8'hE7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/deserializer.md
# deserializer

Serial-to-parallel receiver: recovers 8-bit bytes from an LSB-first serial bit stream, the receive-side counterpart of the team's serializer. Locks to a framing sync byte, strips it, and presents payload bytes on a valid/ready output port with a one-entry holding register. Sits between the serial link pin (after any CDC) and the parallel byte-stream consumer.

## Interface
- `SYNC_WORD`, 8'hA5: framing byte, LSB received first
- `FRAME_BYTES`, 4: payload bytes between consecutive sync bytes, 1..255
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `data_in`  in  1  serial bit, sampled only when `data_in_valid`=1
- `data_in_valid`  in  1  bit qualifier; 0 = idle cycle, no shift
- `data_out`  out  8  received payload byte, bit 0 = first bit received
- `data_out_valid`  out  1  `data_out` holds an unconsumed byte
- `data_out_ready`  in  1  consumer accepts the byte when `data_out_valid`=1
- `locked`  out  1  frame alignment acquired
- `sync_err`  out  1  one-cycle pulse on a failed sync check
- `overflow`  out  1  sticky; payload byte dropped because the holding register was full

## Operation
- Shift register `sr[7:0]`: on each qualified bit, `sr <= {data_in, sr[7:1]}`. Bit counter `bit_cnt` counts 0..7; byte counter `byte_cnt` counts 0..FRAME_BYTES-1.
- FSM states:
  - HUNT: `locked`=0. Sliding bit-by-bit compare. A fill counter requires 8 qualified bits since entering HUNT. When full and `{data_in, sr[7:1]} == SYNC_WORD` on a qualified bit, go to PAYLOAD with `bit_cnt`=0 and `byte_cnt`=0.
  - PAYLOAD: `locked`=1. On the 8th qualified bit, the assembled byte goes to the holding register and `byte_cnt` increments. After byte FRAME_BYTES-1, go to CHECK.
  - CHECK: `locked`=1. Collect 8 bits.
    - Match with SYNC_WORD: go to PAYLOAD. The sync byte is never output.
    - Mismatch: go to HUNT, clear the fill counter, pulse `sync_err` for one cycle. The mismatched byte is discarded.
- Holding register rules:
  - Load when a byte completes AND (`data_out_valid`=0 OR `data_out_ready`=1).
  - Byte completing while `data_out_valid`=1 and `data_out_ready`=0: the new byte is dropped, the old byte is kept, and `overflow` is set. `overflow` clears only on `rst`.
  - Accept without a new byte: `data_out_valid` goes to 0. `data_out` holds its last value.
  - Simultaneous accept and new byte: load the new byte, `data_out_valid` stays 1, no overflow.
- `data_in_valid`=0: all counters, `sr` and FSM state hold. Gaps of any length are legal.

## Timing
- Reset values: `data_out`=8'h00, `data_out_valid`=0, `locked`=0, `sync_err`=0, `overflow`=0, state HUNT, all counters 0, `sr`=0.
- Reset asserted mid-byte or mid-frame discards partial data immediately (asynchronous).
- Byte latency: `data_out`/`data_out_valid` update at the same edge that samples the byte's 8th bit, so they are visible in the following cycle.
- Back-to-back bytes with continuous `data_in_valid` arrive every 8 cycles. The consumer has 8 cycles to accept before overflow.
- `locked` rises at the edge sampling the last sync bit in HUNT. It falls at the edge sampling the last bit of a bad sync byte, coincident with the `sync_err` pulse.
- `data_out_ready` is ignored when `data_out_valid`=0.

## Structure
- Package `deserializer_pkg`: FSM state enum (HUNT, PAYLOAD, CHECK), default SYNC_WORD and FRAME_BYTES constants, byte width 8.
- One sub-module `deser_out_reg`: the 8-bit valid/ready holding register with overflow detection. The FSM, shifter and counters stay in `deserializer`.

## Test plan
- Lock and receive: FRAME_BYTES=2; send 0xA5, 0x3C, 0xC3, 0xA5 with `data_out_ready`=1 → `locked` rises after bit 8; `data_out` = 0x3C then 0xC3, each valid 1 cycle; sync byte never output.
- Misaligned hunt: 3 junk bits 1,0,1, then 0xA5, 0x11, 0x22 → lock after the 11th bit; outputs 0x11, 0x22.
- Bad sync: after a locked frame, send 0x5A in the sync slot → one-cycle `sync_err`, `locked`=0, no byte output; a later 0xA5 relocks.
- Backpressure: hold `data_out_ready`=0 across two payload bytes 0x01, 0x02 → `data_out` stays 0x01, `overflow`=1 and stays 1; assert ready → 0x01 accepted, `data_out_valid`=0.
- Simultaneous accept and load: ready pulses on the exact cycle byte 0x02 completes → 0x02 loaded, `data_out_valid` stays 1, `overflow`=0.
- Gaps and reset: random `data_in_valid` gaps give identical bytes; async `rst` mid-byte clears all outputs within the same cycle and state returns to HUNT.
